// File: rtl/alu_issue_unit_if.sv
// alu_issue_unit_if
//   Request/response handshake bundle for alu_issue_unit.
//   req_*  : operation request (valid/ready), opcode + two 8-bit operands.
//   rsp_*  : captured ALU result (valid/ready), result, masked carry, opcode echo.
//   slave  : the issue unit side (consumes requests, produces responses).
//   master : the requester side.
interface alu_issue_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_ctrl;
  logic [7:0] req_x;
  logic [7:0] req_y;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_carry;
  logic [3:0] rsp_ctrl;

  modport slave (
    input  req_valid, req_ctrl, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_carry, rsp_ctrl
  );

  modport master (
    output req_valid, req_ctrl, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_carry, rsp_ctrl
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Request-side driver for an external 8-bit combinational ALU. Requests are
//   buffered in a DEPTH-entry FIFO, presented to the ALU one per ISSUE cycle,
//   and the result is held in a response register under valid/ready
//   backpressure. A rotating XOR signature and a saturating op counter track
//   completed responses.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   bus         : alu_issue_unit_if.slave (req_* in, rsp_* out)
//   alu_ctrl/x/y: to the ALU; driven from the FIFO head only in ISSUE
//   alu_out/carry: from the ALU, captured at the end of ISSUE
//   sig         : running response signature
//   op_count    : completed response count, saturating at 16'hFFFF
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_unit_if.slave  bus,
  output logic [3:0]       alu_ctrl,
  output logic [7:0]       alu_x,
  output logic [7:0]       alu_y,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic [7:0]       sig,
  output logic [15:0]      op_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] OP_NOP = 4'b1101;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [7:0] x;
    logic [7:0] y;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state_q, state_d;
  req_t           mem_q [DEPTH];
  req_t           mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           req_ready_q, req_ready_d;
  logic [7:0]     rsp_out_q, rsp_out_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic [3:0]     rsp_ctrl_q, rsp_ctrl_d;
  logic [7:0]     sig_q, sig_d;
  logic [15:0]    op_count_q, op_count_d;

  req_t head;
  logic push, pop, rsp_hs;

  assign head = mem_q[rd_ptr_q];

  // req_ready_q already implies count < DEPTH, so it alone gates the push.
  assign push   = bus.req_valid & req_ready_q;
  assign pop    = (state_q == ISSUE);
  assign rsp_hs = (state_q == RESP) & bus.rsp_ready;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
    rsp_ctrl_d  = rsp_ctrl_q;
    sig_d       = sig_q;
    op_count_d  = op_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{ctrl: bus.req_ctrl, x: bus.req_x, y: bus.req_y};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    unique case (state_q)
      IDLE: if (count_q != '0) state_d = ISSUE;
      ISSUE: begin
        // Only add/sub produce a meaningful carry; all others report 0.
        rsp_out_d   = alu_out;
        rsp_carry_d = alu_carry & (head.ctrl[3:1] == 3'b000);
        rsp_ctrl_d  = head.ctrl;
        state_d     = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = (count_q != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    if (rsp_hs) begin
      sig_d = {sig_q[6:0], sig_q[7]} ^ rsp_out_q;
      if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
    end

    // Registered from the next count, so it never advertises space that a
    // push in the same cycle has just consumed.
    req_ready_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ctrl_q  <= '0;
      sig_q       <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_ctrl_q  <= rsp_ctrl_d;
      sig_q       <= sig_d;
      op_count_q  <= op_count_d;
    end
  end

  // Payload storage needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ALU inputs depend only on state and FIFO storage (no input-to-output path).
  assign alu_ctrl = (state_q == ISSUE) ? head.ctrl : OP_NOP;
  assign alu_x    = (state_q == ISSUE) ? head.x    : 8'h00;
  assign alu_y    = (state_q == ISSUE) ? head.y    : 8'h00;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_ctrl  = rsp_ctrl_q;
  assign sig           = sig_q;
  assign op_count      = op_count_q;
endmodule
